ebr_sp_burst_ctrl: RTL and testbench

- Burst initiator that drives the port of a single-port 16K embedded block RAM (SP16KC-class) from a simple request/stream interface.
- Converts one burst request into consecutive CE/WE/address/data cycles, and for reads realigns RAM output data to the configured output-register latency.
- Sits between fabric logic (DMA, buffers, BIST) and one EBR instance in the ECP3 library flow.

---
 rtl/ebr_sp_burst_ctrl.sv | 90 +++++++++
 tb/tb_ebr_sp_burst_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebr_sp_burst_ctrl.sv
// ebr_sp_burst_ctrl: turns one burst request into consecutive single-port EBR cycles and realigns read data to the output-register latency
module ebr_sp_burst_ctrl #(
  parameter int DATA_WIDTH = 18,
  parameter string REGMODE = "NOREG",
  parameter logic [2:0] CSDECODE = 3'b000,
  parameter int LEN_WIDTH = 5,
  localparam int SHIFT = DATA_WIDTH == 18 ? 4 : DATA_WIDTH == 9 ? 3 : DATA_WIDTH == 4 ? 2 : DATA_WIDTH == 2 ? 1 : 0,
  localparam int WA = 14 - SHIFT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [WA-1:0]         req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  busy,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic                  mem_oce,
  output logic [2:0]            mem_cs,
  output logic                  mem_rst,
  output logic [13:0]           mem_ad,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_do
);
  localparam int L = (REGMODE == "OUTREG") ? 2 : 1;
  localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, DRAIN = 2'd3;
  logic [1:0] state;
  logic [WA-1:0] word_addr;
  logic [LEN_WIDTH-1:0] count, len;
  logic [L-1:0] vpipe, lpipe;
  logic wdone, issue, beat, last;
  logic [DATA_WIDTH-1:0] hold;
  always_comb begin
    issue = state == READ;
    beat = state == WRITE && wr_valid;
    last = count == len;
  end
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign wr_ready = state == WRITE;
  assign mem_ce = issue || beat;
  assign mem_we = beat;
  assign mem_oce = L == 2;
  assign mem_cs = CSDECODE;
  assign mem_rst = RST;
  assign mem_ad = 14'(word_addr) << SHIFT;
  assign mem_di = wr_data;
  assign rd_valid = vpipe[L-1];
  assign rd_data = rd_valid ? mem_do : hold;
  assign done = wdone || lpipe[L-1];
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      word_addr <= '0;
      count <= '0;
      len <= '0;
      vpipe <= '0;
      lpipe <= '0;
      wdone <= 1'b0;
      hold <= '0;
    end else begin
      vpipe <= (vpipe << 1) | L'(issue);
      lpipe <= (lpipe << 1) | L'(issue && last);
      wdone <= beat && last;
      if (rd_valid) hold <= mem_do;
      if (state == IDLE) begin
        if (req_valid) begin
          word_addr <= req_addr;
          len <= req_len;
          count <= '0;
          state <= req_write ? WRITE : READ;
        end
      end else if (issue || beat) begin
        word_addr <= word_addr + 1'b1;
        count <= count + 1'b1;
        if (last) state <= issue ? DRAIN : IDLE;
      end else if (state == DRAIN && vpipe == '0) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ebr_sp_burst_ctrl.sv
// tb_ebr_sp_burst_ctrl: randomized self-checking bench for ebr_sp_burst_ctrl against a behavioural EBR and a scoreboard memory
module tb_ebr_sp_burst_ctrl;
  logic clk = 1'b0, rst = 1'b1, seed = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, wr_valid = 1'b0;
  logic [9:0] req_addr = '0;
  logic [4:0] req_len = '0;
  logic [17:0] wr_data = '0;
  logic a_req_ready, a_wr_ready, a_rd_valid, a_done, a_busy, a_ce, a_we, a_oce, a_mrst;
  logic b_req_ready, b_wr_ready, b_rd_valid, b_done, b_busy, b_ce, b_we, b_oce, b_mrst;
  logic [2:0] a_cs, b_cs, c_cs;
  logic [13:0] a_ad, b_ad, c_ad;
  logic [17:0] a_di, a_rd_data, a_do, b_di, b_rd_data, b_do, b_do1;
  logic c_req_valid = 1'b0, c_req_write = 1'b0, c_wr_valid = 1'b0;
  logic [10:0] c_req_addr = '0;
  logic [4:0] c_req_len = '0;
  logic [8:0] c_wr_data = '0, c_do = '0, c_di, c_rd_data;
  logic c_req_ready, c_wr_ready, c_rd_valid, c_done, c_busy, c_ce, c_we, c_oce, c_mrst;
  logic [17:0] ram_a [1024];
  logic [17:0] ram_b [1024];
  logic [17:0] ref_m [1024];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  ebr_sp_burst_ctrl #(.DATA_WIDTH(18), .REGMODE("NOREG")) u_a (
    .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(a_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(a_wr_ready),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .done(a_done), .busy(a_busy), .mem_ce(a_ce), .mem_we(a_we),
    .mem_oce(a_oce), .mem_cs(a_cs), .mem_rst(a_mrst), .mem_ad(a_ad), .mem_di(a_di), .mem_do(a_do));
  ebr_sp_burst_ctrl #(.DATA_WIDTH(18), .REGMODE("OUTREG")) u_b (
    .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(b_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(b_wr_ready),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .done(b_done), .busy(b_busy), .mem_ce(b_ce), .mem_we(b_we),
    .mem_oce(b_oce), .mem_cs(b_cs), .mem_rst(b_mrst), .mem_ad(b_ad), .mem_di(b_di), .mem_do(b_do));
  ebr_sp_burst_ctrl #(.DATA_WIDTH(9), .REGMODE("NOREG")) u_c (
    .CLK(clk), .RST(rst), .req_valid(c_req_valid), .req_ready(c_req_ready), .req_write(c_req_write),
    .req_addr(c_req_addr), .req_len(c_req_len), .wr_data(c_wr_data), .wr_valid(c_wr_valid), .wr_ready(c_wr_ready),
    .rd_data(c_rd_data), .rd_valid(c_rd_valid), .done(c_done), .busy(c_busy), .mem_ce(c_ce), .mem_we(c_we),
    .mem_oce(c_oce), .mem_cs(c_cs), .mem_rst(c_mrst), .mem_ad(c_ad), .mem_di(c_di), .mem_do(c_do));
  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 1024; i++) begin
        ram_a[i] <= 18'(i);
        ram_b[i] <= 18'(i);
      end
    end else begin
      if (a_ce) begin
        if (a_we) ram_a[a_ad[13:4]] <= a_di;
        else a_do <= ram_a[a_ad[13:4]];
      end
      if (b_ce) begin
        if (b_we) ram_b[b_ad[13:4]] <= b_di;
        else b_do1 <= ram_b[b_ad[13:4]];
      end
      if (b_oce) b_do <= b_do1;
    end
  end
  task automatic wait_idle();
    int k = 0;
    while (!(a_req_ready && b_req_ready) && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (!(a_req_ready && b_req_ready)) begin
      n_bad++;
      $display("FAIL idle_wait: req_ready a=%b b=%b, required 1 1", a_req_ready, b_req_ready);
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    seed = 1'b0;
    #1;
    n_cmp++;
    if ({a_req_ready, a_busy, a_rd_valid, a_done, a_ce, a_we, a_mrst, a_oce, a_cs} !== 11'b10000010000 ||
        {b_req_ready, b_busy, b_rd_valid, b_done, b_ce, b_we, b_mrst, b_oce, b_cs} !== 11'b10000011000) begin
      n_bad++;
      $display("FAIL reset_state: a=%b_%b b=%b_%b", {a_req_ready, a_busy, a_rd_valid, a_done, a_ce, a_we, a_mrst, a_oce}, a_cs,
               {b_req_ready, b_busy, b_rd_valid, b_done, b_ce, b_we, b_mrst, b_oce}, b_cs);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({a_req_ready, a_busy, a_ce, a_mrst, c_req_ready, c_busy, c_ce, c_rd_valid, c_mrst, c_oce} !== 10'b1000100000) begin
      n_bad++;
      $display("FAIL reset_release: a=%b c=%b, required 1000 100000", {a_req_ready, a_busy, a_ce, a_mrst},
               {c_req_ready, c_busy, c_ce, c_rd_valid, c_mrst, c_oce});
    end
  endtask
  task automatic test_write(input int addr, input int len, input logic [31:0] pat, input bit seq);
    int beat = 0, k = 0, wa;
    logic v;
    logic [17:0] d;
    logic [13:0] ea;
    wait_idle();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr[9:0]; req_len = len[4:0];
    #1;
    n_cmp++;
    if ({a_req_ready, b_req_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL wr_accept: req_ready=%b, required 11", {a_req_ready, b_req_ready});
    end
    while (beat <= len && k < 200) begin
      @(negedge clk);
      req_valid = 1'b0; req_addr = 10'($urandom);
      v = pat == 0 ? ($urandom_range(3) != 0) : (k < 32 ? pat[k] : 1'b1);
      d = seq ? 18'(beat + 1) : 18'($urandom);
      wr_valid = v; wr_data = d;
      #1;
      n_cmp++;
      if ({a_ce, a_we, a_wr_ready, a_busy, a_done, a_req_ready, b_ce, b_we, b_wr_ready, b_busy, b_done, b_req_ready} !==
          {v, v, 4'b1100, v, v, 4'b1100}) begin
        n_bad++;
        $display("FAIL wr_ctrl cyc %0d: a=%b b=%b, required %b", k, {a_ce, a_we, a_wr_ready, a_busy, a_done, a_req_ready},
                 {b_ce, b_we, b_wr_ready, b_busy, b_done, b_req_ready}, {v, v, 4'b1100});
      end
      if (v) begin
        wa = (addr + beat) % 1024;
        ea = 14'(wa * 16);
        n_cmp++;
        if (a_ad !== ea || b_ad !== ea || a_di !== d) begin
          n_bad++;
          $display("FAIL wr_beat %0d: ad a=%h b=%h di=%h, required ad=%h di=%h", beat, a_ad, b_ad, a_di, ea, d);
        end
        ref_m[wa] = d;
        beat++;
      end
      k++;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    n_cmp++;
    if (beat != len + 1 || {a_done, a_busy, a_req_ready, a_ce, b_done, b_busy, b_req_ready} !== 7'b1010101) begin
      n_bad++;
      $display("FAIL wr_done: beats=%0d a=%b b=%b, required beats=%0d 1010 101", beat, {a_done, a_busy, a_req_ready, a_ce},
               {b_done, b_busy, b_req_ready}, len + 1);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({a_done, b_done} !== 2'b00) begin
      n_bad++;
      $display("FAIL wr_done_pulse: done=%b, required 00", {a_done, b_done});
    end
  endtask
  task automatic test_read(input int addr, input int len);
    logic ce_e, av_e, bv_e;
    logic [13:0] ea;
    wait_idle();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr[9:0]; req_len = len[4:0];
    #1;
    n_cmp++;
    if ({a_req_ready, b_req_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL rd_accept: req_ready=%b, required 11", {a_req_ready, b_req_ready});
    end
    for (int c = 1; c <= len + 5; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      ce_e = c <= len + 1;
      av_e = c >= 2 && c <= len + 2;
      bv_e = c >= 3 && c <= len + 3;
      n_cmp++;
      if ({a_ce, a_we, b_ce, b_we, a_rd_valid, a_done, b_rd_valid, b_done} !==
          {ce_e, 1'b0, ce_e, 1'b0, av_e, c == len + 2, bv_e, c == len + 3}) begin
        n_bad++;
        $display("FAIL rd_flags cyc %0d: got %b, required %b", c, {a_ce, a_we, b_ce, b_we, a_rd_valid, a_done, b_rd_valid, b_done},
                 {ce_e, 1'b0, ce_e, 1'b0, av_e, c == len + 2, bv_e, c == len + 3});
      end
      if (ce_e) begin
        ea = 14'(((addr + c - 1) % 1024) * 16);
        n_cmp++;
        if (a_ad !== ea || b_ad !== ea) begin
          n_bad++;
          $display("FAIL rd_addr cyc %0d: a=%h b=%h, required %h", c, a_ad, b_ad, ea);
        end
      end
      if (av_e) begin
        n_cmp++;
        if (a_rd_data !== ref_m[(addr + c - 2) % 1024]) begin
          n_bad++;
          $display("FAIL rd_data_noreg cyc %0d: got %h, required %h", c, a_rd_data, ref_m[(addr + c - 2) % 1024]);
        end
      end
      if (bv_e) begin
        n_cmp++;
        if (b_rd_data !== ref_m[(addr + c - 3) % 1024]) begin
          n_bad++;
          $display("FAIL rd_data_outreg cyc %0d: got %h, required %h", c, b_rd_data, ref_m[(addr + c - 3) % 1024]);
        end
      end
    end
    n_cmp++;
    if (a_rd_data !== ref_m[(addr + len) % 1024] || b_rd_data !== ref_m[(addr + len) % 1024]) begin
      n_bad++;
      $display("FAIL rd_hold: a=%h b=%h, required %h", a_rd_data, b_rd_data, ref_m[(addr + len) % 1024]);
    end
  endtask
  task automatic test_reset_mid_read();
    wait_idle();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'($urandom); req_len = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_ce, a_mrst, b_ce, b_mrst} !== 4'b1111) begin
      n_bad++;
      $display("FAIL rst_mid_issue: got %b, required 1111", {a_ce, a_mrst, b_ce, b_mrst});
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({a_ce, a_rd_valid, a_req_ready, a_busy, a_done, b_ce, b_rd_valid, b_req_ready, b_busy, b_done} !== 10'b0010000100) begin
        n_bad++;
        $display("FAIL rst_mid_after %0d: got %b, required 0010000100", c,
                 {a_ce, a_rd_valid, a_req_ready, a_busy, a_done, b_ce, b_rd_valid, b_req_ready, b_busy, b_done});
      end
    end
  endtask
  task automatic test_width9();
    @(negedge clk);
    c_req_valid = 1'b1; c_req_write = 1'b1; c_req_addr = 11'h7FF; c_req_len = 5'd1;
    #1;
    n_cmp++;
    if (c_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL w9_accept: req_ready=%b, required 1", c_req_ready);
    end
    @(negedge clk);
    c_req_valid = 1'b0; c_wr_valid = 1'b1; c_wr_data = 9'h1AB;
    #1;
    n_cmp++;
    if ({c_ce, c_we, c_wr_ready} !== 3'b111 || c_ad !== 14'h3FF8 || c_di !== 9'h1AB) begin
      n_bad++;
      $display("FAIL w9_beat0: ctrl=%b ad=%h di=%h, required 111 3ff8 1ab", {c_ce, c_we, c_wr_ready}, c_ad, c_di);
    end
    @(negedge clk);
    c_wr_data = 9'h055;
    #1;
    n_cmp++;
    if ({c_ce, c_we} !== 2'b11 || c_ad !== 14'h0000 || c_di !== 9'h055) begin
      n_bad++;
      $display("FAIL w9_beat1: ctrl=%b ad=%h di=%h, required 11 0000 055", {c_ce, c_we}, c_ad, c_di);
    end
    @(negedge clk);
    c_wr_valid = 1'b0;
    #1;
    n_cmp++;
    if ({c_done, c_busy, c_req_ready, c_ce} !== 4'b1010) begin
      n_bad++;
      $display("FAIL w9_done: got %b, required 1010", {c_done, c_busy, c_req_ready, c_ce});
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(1) == 1) test_write(int'($urandom_range(1023)), int'($urandom_range(31)), 32'd0, 1'b0);
      else test_read(int'($urandom_range(1023)), int'($urandom_range(31)));
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ref_m[i] = 18'(i);
    test_reset();
    test_write(10'h3FE, 3, 32'd0, 1'b1);
    test_read(10'h3FE, 3);
    test_read(int'($urandom_range(1023)), 0);
    test_write(int'($urandom_range(1023)), 2, 32'b11001, 1'b0);
    test_reset_mid_read();
    test_read(int'($urandom_range(1023)), 5);
    test_width9();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion before 500000");
    $fatal(1);
  end
endmodule
